spi_flash_fetch: RTL and testbench

Instruction fetch unit between the external SPI NOR flash (single-SPI, mode 0) and the CPU fetch/decode stage. It takes a 16-bit word address from the PC and issues a flash READ (0x03) command with a 24-bit byte address. It shifts in one 16-bit instruction MSB-first and returns it with a one-cycle ready pulse. Sequential fetches reuse the open flash transaction (CS held low), so the command and address phases are skipped.

---
 rtl/spi_flash_fetch.sv | 146 ++++++++++++++
 tb/tb_spi_flash_fetch.sv | 272 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_flash_fetch.sv
// Instruction fetch from single-SPI NOR flash (mode 0, READ 0x03).
// CS stays low after a fetch, so a PC+1 fetch only clocks the 16 data bits.
module spi_flash_fetch #(
  parameter int unsigned CLK_DIV   = 1,
  parameter logic [7:0]  CMD_READ  = 8'h03,
  parameter int unsigned CS_MIN    = 2,
  parameter bit          STREAM_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req,
  input  logic [15:0] addr,
  input  logic        flush,
  output logic [15:0] instr,
  output logic        ready,
  output logic        busy,
  output logic        spi_cs_n,
  output logic        spi_sclk,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  typedef enum logic [2:0] {IDLE, CMD, ADDR, READ, DONE, HOLD, DESEL} state_t;

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);
  localparam logic [7:0] CS_LAST  = 8'(CS_MIN - 1);

  state_t      state, state_nx;
  logic [7:0]  div_cnt, desel_cnt;
  logic [4:0]  bit_cnt, bit_last;
  logic [31:0] tx_sr;
  logic [15:0] rx_sr, cur_addr, next_addr, cmd_addr;
  logic        sclk_q, pending, stream_vld;
  logic        shifting, phase_end, rise, fall, bit_end, accept, abort;

  assign shifting  = (state == CMD) || (state == ADDR) || (state == READ);
  assign phase_end = shifting && (div_cnt == DIV_LAST);
  assign rise      = phase_end && !sclk_q;
  assign fall      = phase_end && sclk_q;
  assign bit_last  = (state == CMD) ? 5'd7 : (state == ADDR) ? 5'd23 : 5'd15;
  assign bit_end   = fall && (bit_cnt == bit_last);
  assign abort     = flush && (state != IDLE) && (state != DESEL);
  // A request taken during HOLD/DESEL is replayed from cur_addr once CS has been high long enough.
  assign accept    = req && ((state == IDLE) || ((state == HOLD) && !flush) ||
                             ((state == DESEL) && !pending));
  assign cmd_addr  = accept ? addr : cur_addr;
  assign spi_sclk  = sclk_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    spi_cs_n = 1'b0;
    spi_mosi = 1'b0;
    busy     = 1'b0;
    ready    = 1'b0;
    case (state)
      IDLE: begin
        spi_cs_n = 1'b1;
        if (req) state_nx = CMD;
      end
      CMD: begin
        busy     = 1'b1;
        spi_mosi = tx_sr[31];
        if (bit_end) state_nx = ADDR;
      end
      ADDR: begin
        busy     = 1'b1;
        spi_mosi = tx_sr[31];
        if (bit_end) state_nx = READ;
      end
      READ: begin
        busy = 1'b1;
        if (bit_end) state_nx = DONE;
      end
      DONE: begin
        ready    = 1'b1;
        state_nx = STREAM_EN ? HOLD : DESEL;
      end
      HOLD: begin
        if (req) state_nx = (stream_vld && (addr == next_addr)) ? READ : DESEL;
      end
      DESEL: begin
        spi_cs_n = 1'b1;
        busy     = pending;
        if (desel_cnt == CS_LAST) state_nx = (pending || accept) ? CMD : IDLE;
      end
      default: state_nx = IDLE;
    endcase
    if (abort) state_nx = DESEL;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div_cnt    <= '0;
      desel_cnt  <= '0;
      bit_cnt    <= '0;
      sclk_q     <= 1'b0;
      tx_sr      <= '0;
      rx_sr      <= '0;
      instr      <= '0;
      cur_addr   <= '0;
      next_addr  <= '0;
      pending    <= 1'b0;
      stream_vld <= 1'b0;
    end else begin
      if (state_nx != state) begin
        div_cnt <= '0;
        sclk_q  <= 1'b0;
        bit_cnt <= '0;
      end else if (phase_end) begin
        div_cnt <= '0;
        sclk_q  <= ~sclk_q;
        if (sclk_q) bit_cnt <= bit_cnt + 5'd1;
      end else if (shifting) begin
        div_cnt <= div_cnt + 8'd1;
      end

      if (state_nx == CMD && state != CMD)
        tx_sr <= {CMD_READ, 7'b0, cmd_addr, 1'b0};
      else if (state_nx == DESEL || state_nx == IDLE)
        tx_sr <= '0;
      else if (fall && (state == CMD || state == ADDR))
        tx_sr <= {tx_sr[30:0], 1'b0};

      if (rise && state == READ) rx_sr <= {rx_sr[14:0], spi_miso};
      if (state == READ && state_nx == DONE) instr <= rx_sr;
      if (state == DONE) next_addr <= cur_addr + 16'd1;
      if (accept) cur_addr <= addr;

      desel_cnt <= (state == DESEL) ? desel_cnt + 8'd1 : 8'd0;

      if (state_nx == DESEL || state_nx == IDLE) stream_vld <= 1'b0;
      else if (state == DONE)                    stream_vld <= STREAM_EN;

      if (abort || (state == DESEL && state_nx != DESEL))
        pending <= 1'b0;
      else if (accept && (state == DESEL || state_nx == DESEL))
        pending <= 1'b1;
    end
  end

endmodule

// File: tb/tb_spi_flash_fetch.sv
// Two fetch units (CLK_DIV 1 and 2) against a behavioural SPI NOR model;
// expected fetches are queued at issue and popped by a monitor on ready.
module tb_spi_flash_fetch;

  localparam int CS_MIN = 2;

  typedef struct {
    int          inst;
    logic [15:0] a;
    logic [15:0] data;
    bit          cold;
    bit          jump;
    int          lat;
    int          t0;
    int          cmds0;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req [2];
  logic        flush [2];
  logic [15:0] addr_v [2];
  logic [15:0] instr_v [2];
  logic        ready [2];
  logic        busy [2];
  logic        cs_n [2];
  logic        sclk [2];
  logic        mosi [2];
  int          fl_cmds [2];
  logic [31:0] fl_hdr [2];

  exp_t        sbq [$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  bit          open_s [2];
  logic [15:0] nxt [2];
  int          hi_cnt [2];
  int          last_run [2];
  logic        prev_rdy [2];
  logic        prev_mosi [2];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [15:0] word_val(input logic [15:0] w);
    case (w)
      16'h0000: return 16'h620A;
      16'h0001: return 16'h6414;
      16'h0003: return 16'h8600;
      16'h0004: return 16'h7800;
      16'h0009: return 16'h9FFF;
      default:  return 16'(w * 16'h9E37) ^ 16'h5A5A;
    endcase
  endfunction

  function automatic logic [7:0] byte_val(input logic [23:0] b);
    logic [15:0] w;
    w = word_val(b[16:1]);
    return b[0] ? w[7:0] : w[15:8];
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_inst
    logic        miso = 1'b0;
    int          bitn = 0;
    int          dbit = 0;
    int          cmds = 0;
    logic [31:0] hdr = '0;
    logic [23:0] ptr = '0;
    logic [7:0]  bv;

    spi_flash_fetch #(.CLK_DIV(g + 1), .CMD_READ(8'h03), .CS_MIN(CS_MIN), .STREAM_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n), .req(req[g]), .addr(addr_v[g]), .flush(flush[g]),
      .instr(instr_v[g]), .ready(ready[g]), .busy(busy[g]), .spi_cs_n(cs_n[g]),
      .spi_sclk(sclk[g]), .spi_mosi(mosi[g]), .spi_miso(miso)
    );

    assign fl_cmds[g] = cmds;
    assign fl_hdr[g]  = hdr;

    // Flash side: 8-bit opcode + 24-bit address, then bytes stream out with auto-increment.
    always @(posedge sclk[g] or posedge cs_n[g]) begin
      if (cs_n[g]) bitn = 0;
      else if (bitn < 32) begin
        hdr  = {hdr[30:0], mosi[g]};
        bitn = bitn + 1;
        if (bitn == 32) begin
          ptr  = hdr[23:0];
          dbit = 0;
          cmds = cmds + 1;
        end
      end
    end

    always @(negedge sclk[g] or posedge cs_n[g]) begin
      if (cs_n[g]) miso = 1'b0;
      else if (bitn >= 32 && hdr[31:24] == 8'h03) begin
        bv   = byte_val(ptr);
        miso = bv[7 - dbit];
        dbit = dbit + 1;
        if (dbit == 8) begin
          dbit = 0;
          ptr  = ptr + 24'd1;
        end
      end
    end
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, expv, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    forever begin
      @(negedge clk);
      for (int i = 0; i < 2; i++) begin
        if (cs_n[i] === 1'b1) hi_cnt[i]++;
        else begin
          if (hi_cnt[i] != 0) last_run[i] = hi_cnt[i];
          hi_cnt[i] = 0;
        end
        if (mosi[i] !== prev_mosi[i]) chk("mosi_change_sclk_low", {31'b0, sclk[i]}, 32'd0);
        prev_mosi[i] = mosi[i];
        if (ready[i] === 1'b1) begin
          chk("ready_not_back_to_back", {31'b0, prev_rdy[i]}, 32'd0);
          chk("sclk_low_at_ready", {31'b0, sclk[i]}, 32'd0);
          if (sbq.size() == 0) begin
            errors++;
            $display("FAIL unexpected_ready: inst %0d instr %h with no fetch outstanding", i, instr_v[i]);
          end else begin
            e = sbq.pop_front();
            chk("ready_instance", i, e.inst);
            chk("instr", {16'b0, instr_v[i]}, {16'b0, e.data});
            chk("latency", cyc - e.t0, e.lat);
            chk("commands_issued", fl_cmds[i] - e.cmds0, e.cold ? 1 : 0);
            if (e.cold) chk("cmd_and_address", fl_hdr[i], {8'h03, 7'b0, e.a, 1'b0});
            if (e.jump) chk("cs_high_cycles", last_run[i], CS_MIN);
          end
        end
        prev_rdy[i] = ready[i];
      end
    end
  endtask

  task automatic issue(input int i, input logic [15:0] a);
    @(negedge clk);
    addr_v[i] = a;
    req[i]    = 1'b1;
  endtask

  task automatic fetch(input int i, input logic [15:0] a);
    exp_t e;
    int   n;
    e.inst  = i;
    e.a     = a;
    e.data  = word_val(a);
    e.cold  = !(open_s[i] && a == nxt[i]);
    e.jump  = open_s[i] && e.cold;
    e.lat   = 1 + (e.jump ? CS_MIN : 0) + (e.cold ? 48 : 16) * 2 * (i + 1);
    @(negedge clk);
    e.t0    = cyc;
    e.cmds0 = fl_cmds[i];
    sbq.push_back(e);
    addr_v[i] = a;
    req[i]    = 1'b1;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ready[i] !== 1'b1 && n < 3000);
    req[i] = 1'b0;
    if (n >= 3000) begin
      errors++;
      $display("FAIL ready_timeout: inst %0d addr %h no ready within %0d cycles", i, a, n);
    end
    open_s[i] = 1'b1;
    nxt[i]    = a + 16'd1;
  endtask

  task automatic flush_fetch(input int i, input logic [15:0] a, input int k);
    issue(i, a);
    repeat (k) @(negedge clk);
    flush[i] = 1'b1;
    req[i]   = 1'b0;
    @(negedge clk);
    flush[i] = 1'b0;
    chk("cs_high_after_flush", {31'b0, cs_n[i]}, 32'd1);
    chk("sclk_low_after_flush", {31'b0, sclk[i]}, 32'd0);
    repeat (2) @(negedge clk);
    chk("busy_clear_after_flush", {31'b0, busy[i]}, 32'd0);
    @(negedge clk);
    open_s[i] = 1'b0;
  endtask

  task automatic chk_reset_outputs(input int i);
    chk("rst_cs_n", {31'b0, cs_n[i]}, 32'd1);
    chk("rst_sclk", {31'b0, sclk[i]}, 32'd0);
    chk("rst_mosi", {31'b0, mosi[i]}, 32'd0);
    chk("rst_ready", {31'b0, ready[i]}, 32'd0);
    chk("rst_busy", {31'b0, busy[i]}, 32'd0);
    chk("rst_instr", {16'b0, instr_v[i]}, 32'd0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  initial begin
    int          i, sel, n;
    logic [15:0] a;
    rst_n = 1'b0;
    for (int j = 0; j < 2; j++) begin
      req[j] = 1'b0; flush[j] = 1'b0; addr_v[j] = '0; open_s[j] = 1'b0; nxt[j] = '0;
      hi_cnt[j] = 0; last_run[j] = 0; prev_rdy[j] = 1'b0; prev_mosi[j] = 1'b0;
    end
    repeat (3) @(negedge clk);
    chk_reset_outputs(0);
    chk_reset_outputs(1);
    rst_n = 1'b1;
    fork monitor(); join_none

    fetch(0, 16'h0000);
    @(negedge clk);
    chk("cs_held_low_in_stream", {31'b0, cs_n[0]}, 32'd0);
    fetch(0, 16'h0001);
    fetch(0, 16'h0009);
    fetch(1, 16'h0003);
    fetch(1, 16'hFFFF);
    fetch(1, 16'h0000);

    flush_fetch(0, 16'h0007, 40);
    fetch(0, 16'h0004);

    issue(0, 16'h0005);
    repeat (11) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk_reset_outputs(0);
    req[0] = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    open_s[0] = 1'b0;
    open_s[1] = 1'b0;
    fetch(0, 16'h0005);

    for (int r = 0; r < 60; r++) begin
      i   = $urandom_range(0, 1);
      sel = $urandom_range(0, 9);
      if (open_s[i] && sel < 5) a = nxt[i];
      else a = 16'($urandom);
      if (sel == 9) flush_fetch(i, a, $urandom_range(4, 28));
      else fetch(i, a);
    end

    n = 0;
    while (sbq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("scoreboard_drained", sbq.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
